// File: rtl/score_display_ctrl.sv
// Six-digit score display sequencer: arbitrates score/combo sources, converts the
// selected value to BCD with a serial double-dabble engine and registers digits + blank mask.
module score_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned SAT_MAX     = 999_999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] score_value,
  input  logic        score_valid,
  input  logic [19:0] combo_value,
  input  logic        combo_valid,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5,
  output logic [5:0]  blank,
  output logic        showing_combo,
  output logic        busy
);

  localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);
  localparam logic [19:0]   SAT_VAL   = 20'(SAT_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t         state;
  logic           src_combo;
  logic [19:0]    score_reg;
  logic [19:0]    combo_reg;
  logic           pend_score;
  logic           pend_combo;
  logic [TW-1:0]  hold_timer;
  logic [19:0]    operand;
  logic [23:0]    bcd;
  logic [4:0]     iter;
  logic [23:0]    disp_reg;
  logic [5:0]     blank_reg;
  logic           showing_reg;

  logic [22:0]    bcd_adj;
  logic [5:1]     zero_nib;
  logic [5:0]     blank_next;
  logic [19:0]    load_value;
  logic [19:0]    load_sat;
  logic           commit_combo;
  logic           hold_expire;

  // Add-3 correction; the top nibble only needs its low three bits since
  // the bit shifted out of it is always zero for saturated operands.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ? bcd[gi*4 +: 4] + 4'd3
                                                           : bcd[gi*4 +: 4];
    end
    for (gi = 1; gi < 6; gi++) begin : g_blank
      assign zero_nib[gi]   = (bcd[gi*4 +: 4] == 4'd0);
      assign blank_next[gi] = &zero_nib[5:gi];
    end
  endgenerate

  assign bcd_adj[22:20] = (bcd[23:20] >= 4'd5) ? 3'(bcd[23:20] + 4'd3) : bcd[22:20];
  assign blank_next[0]  = 1'b0;

  assign load_value   = pend_combo ? combo_reg : score_reg;
  assign load_sat     = (load_value > SAT_VAL) ? SAT_VAL : load_value;
  assign commit_combo = (state == COMMIT) && src_combo;
  // A combo commit reloading the timer on its last count cancels the expiry.
  assign hold_expire  = (hold_timer == TW'(1)) && !commit_combo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      src_combo   <= 1'b0;
      score_reg   <= '0;
      combo_reg   <= '0;
      pend_score  <= 1'b0;
      pend_combo  <= 1'b0;
      hold_timer  <= '0;
      operand     <= '0;
      bcd         <= '0;
      iter        <= '0;
      disp_reg    <= '0;
      blank_reg   <= 6'b111110;
      showing_reg <= 1'b0;
    end else begin
      if (commit_combo) begin
        hold_timer <= HOLD_LOAD;
      end else if (hold_timer != '0) begin
        hold_timer <= hold_timer - TW'(1);
      end

      case (state)
        IDLE: begin
          if (pend_combo) begin
            operand    <= load_sat;
            bcd        <= '0;
            iter       <= '0;
            src_combo  <= 1'b1;
            pend_combo <= 1'b0;
            state      <= SHIFT;
          end else if (pend_score && (hold_timer == '0)) begin
            operand    <= load_sat;
            bcd        <= '0;
            iter       <= '0;
            src_combo  <= 1'b0;
            pend_score <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= {bcd_adj, operand[19]};
          operand <= {operand[18:0], 1'b0};
          iter    <= iter + 5'd1;
          if (iter == 5'd19) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp_reg    <= bcd;
          blank_reg   <= blank_next;
          showing_reg <= src_combo;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Captures come last so a fresh request survives a same-cycle load.
      if (score_valid) begin
        score_reg  <= score_value;
        pend_score <= 1'b1;
      end
      if (hold_expire) begin
        pend_score <= 1'b1;
      end
      if (combo_valid) begin
        combo_reg  <= combo_value;
        pend_combo <= 1'b1;
      end
    end
  end

  assign digit0        = disp_reg[3:0];
  assign digit1        = disp_reg[7:4];
  assign digit2        = disp_reg[11:8];
  assign digit3        = disp_reg[15:12];
  assign digit4        = disp_reg[19:16];
  assign digit5        = disp_reg[23:20];
  assign blank         = blank_reg;
  assign showing_combo = showing_reg;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: table of score conversions plus
// hand-timed sequences for combo hold, simultaneous requests, overwrite and reset.
module tb_score_display_ctrl;

  logic        clk;
  logic        reset_n;
  logic [19:0] score_value;
  logic        score_valid;
  logic [19:0] combo_value;
  logic        combo_valid;
  logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5;
  logic [5:0]  blank;
  logic        showing_combo;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  score_display_ctrl #(.HOLD_CYCLES(10), .SAT_MAX(999_999)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .score_value   (score_value),
    .score_valid   (score_valid),
    .combo_value   (combo_value),
    .combo_valid   (combo_valid),
    .digit0        (digit0),
    .digit1        (digit1),
    .digit2        (digit2),
    .digit3        (digit3),
    .digit4        (digit4),
    .digit5        (digit5),
    .blank         (blank),
    .showing_combo (showing_combo),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] disp;
  assign disp = {digit5, digit4, digit3, digit2, digit1, digit0};

  typedef struct {
    logic [19:0] value;
    logic [23:0] digits;
    logic [5:0]  blank;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Valid pulses are sampled on the posedge after the first negedge; returns half a cycle later.
  task automatic pulse(input logic [19:0] sv, input logic s_en,
                       input logic [19:0] cv, input logic c_en);
    @(negedge clk);
    score_value = sv;
    score_valid = s_en;
    combo_value = cv;
    combo_valid = c_en;
    @(negedge clk);
    score_valid = 1'b0;
    combo_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [23:0] prev;

    vecs[0]  = '{20'd146,     24'h000146, 6'b111000};
    vecs[1]  = '{20'hFFFFF,   24'h999999, 6'b000000};
    vecs[2]  = '{20'd0,       24'h000000, 6'b111110};
    vecs[3]  = '{20'd5,       24'h000005, 6'b111110};
    vecs[4]  = '{20'd10,      24'h000010, 6'b111100};
    vecs[5]  = '{20'd100000,  24'h100000, 6'b000000};
    vecs[6]  = '{20'd65535,   24'h065535, 6'b100000};
    vecs[7]  = '{20'd1000000, 24'h999999, 6'b000000};
    vecs[8]  = '{20'd9,       24'h000009, 6'b111110};
    vecs[9]  = '{20'd123456,  24'h123456, 6'b000000};
    vecs[10] = '{20'd500,     24'h000500, 6'b111000};

    reset_n     = 1'b0;
    score_value = '0;
    score_valid = 1'b0;
    combo_value = '0;
    combo_valid = 1'b0;
    wait_neg(3);
    check("reset_digits", 32'(disp), 32'h0);
    check("reset_blank", 32'(blank), 32'b111110);
    check("reset_showing", 32'(showing_combo), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wait_neg(2);

    // Score conversions: 22-cycle latency, outputs untouched until commit.
    prev = 24'h0;
    for (int i = 0; i < 11; i++) begin
      pulse(vecs[i].value, 1'b1, 20'd0, 1'b0);
      wait_neg(1);
      check("busy_at_n1", 32'(busy), 32'd1);
      wait_neg(20);
      check("hold_prev_digits", 32'(disp), 32'(prev));
      check("busy_before_commit", 32'(busy), 32'd1);
      wait_neg(1);
      check("vec_digits", 32'(disp), 32'(vecs[i].digits));
      check("vec_blank", 32'(blank), 32'(vecs[i].blank));
      check("vec_busy_done", 32'(busy), 32'd0);
      check("vec_showing", 32'(showing_combo), 32'd0);
      $display("vec %0d value=%0d digits=%h blank=%b", i, vecs[i].value, disp, blank);
      prev = vecs[i].digits;
      wait_neg(2);
    end

    // Combo 25 over score 500: hold 10 cycles, then 500 re-converts (commit + 32).
    pulse(20'd0, 1'b0, 20'd25, 1'b1);
    wait_neg(22);
    check("combo_digits", 32'(disp), 32'h000025);
    check("combo_blank", 32'(blank), 32'b111100);
    check("combo_showing", 32'(showing_combo), 32'd1);
    wait_neg(10);
    check("combo_hold_showing", 32'(showing_combo), 32'd1);
    wait_neg(21);
    check("combo_before_restore", 32'(disp), 32'h000025);
    check("combo_showing_before_restore", 32'(showing_combo), 32'd1);
    wait_neg(1);
    check("restore_digits", 32'(disp), 32'h000500);
    check("restore_showing", 32'(showing_combo), 32'd0);
    $display("combo 25 then restore digits=%h showing=%0d", disp, showing_combo);
    wait_neg(2);

    // Simultaneous score 777 and combo 3.
    pulse(20'd777, 1'b1, 20'd3, 1'b1);
    wait_neg(22);
    check("simul_combo_digits", 32'(disp), 32'h000003);
    check("simul_combo_showing", 32'(showing_combo), 32'd1);
    check("simul_combo_blank", 32'(blank), 32'b111110);
    wait_neg(31);
    check("simul_no_early_777", 32'(disp), 32'h000003);
    wait_neg(1);
    check("simul_score_digits", 32'(disp), 32'h000777);
    check("simul_score_showing", 32'(showing_combo), 32'd0);
    $display("simultaneous 777/3 final digits=%h", disp);
    wait_neg(2);

    // Overwrite: 100 at N, 200 at N+5, 300 at N+10.
    pulse(20'd100, 1'b1, 20'd0, 1'b0);
    wait_neg(4);
    score_value = 20'd200;
    score_valid = 1'b1;
    wait_neg(1);
    score_valid = 1'b0;
    wait_neg(4);
    score_value = 20'd300;
    score_valid = 1'b1;
    wait_neg(1);
    score_valid = 1'b0;
    wait_neg(12);
    check("ovw_first_digits", 32'(disp), 32'h000100);
    wait_neg(21);
    check("ovw_before_second", 32'(disp), 32'h000100);
    check("ovw_busy", 32'(busy), 32'd1);
    wait_neg(1);
    check("ovw_second_digits", 32'(disp), 32'h000300);
    check("ovw_idle", 32'(busy), 32'd0);
    $display("overwrite 100/200/300 final digits=%h", disp);
    wait_neg(2);

    // Reset in the middle of a 999999 conversion.
    pulse(20'd999999, 1'b1, 20'd0, 1'b0);
    wait_neg(9);
    reset_n = 1'b0;
    #1;
    check("mid_rst_digits", 32'(disp), 32'h0);
    check("mid_rst_blank", 32'(blank), 32'b111110);
    check("mid_rst_busy", 32'(busy), 32'd0);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(30);
    check("post_rst_digits", 32'(disp), 32'h0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_blank", 32'(blank), 32'b111110);
    pulse(20'd42, 1'b1, 20'd0, 1'b0);
    wait_neg(22);
    check("post_rst_new_digits", 32'(disp), 32'h000042);
    check("post_rst_new_blank", 32'(blank), 32'b111100);
    $display("reset mid-conversion then 42 digits=%h", disp);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequences the six-digit seven-segment display path.
- Arbitrates between two requesters: the running score, and a transient combo/bonus value that shows for a fixed hold time.
- Converts the selected 20-bit binary value to six BCD digits with a sequential double-dabble engine (no divide/modulo hardware).
- Registered digits and a leading-zero blank mask feed the six per-digit segment decoders.

Parameters:
- HOLD_CYCLES, 50_000_000, clock cycles the combo value stays on display after its conversion commits (must be ≥1).
- SAT_MAX, 999_999, saturation ceiling applied before conversion.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- score_value  in  20  running score, binary
- score_valid  in  1  one-cycle pulse: capture score_value
- combo_value  in  20  combo/bonus value, binary
- combo_valid  in  1  one-cycle pulse: capture combo_value, show for HOLD_CYCLES
- digit0..digit5  out  4 each  BCD digits, digit0 = ones, digit5 = hundred-thousands
- blank  out  6  bit k=1 → digit k suppressed (leading zero)
- showing_combo  out  1  1 while displayed digits come from combo source
- busy  out  1  1 while conversion in flight (SHIFT or COMMIT)

Behaviour:
- Reset (async, reset_n=0), all cleared immediately:
  - digit0..5 = 0, blank = 6'b111110, showing_combo = 0, busy = 0.
  - score_reg = combo_reg = 0, pending flags = 0, hold timer = 0, state = IDLE.
  - Reset asserted mid-conversion discards the conversion; no commit occurs.
- Capture:
  - A valid pulse on edge N writes the value register and sets pend_score/pend_combo.
  - Captures happen in every state. A newer value overwrites an older uncommitted one.
  - A conversion already in flight finishes with its loaded value; the new value converts afterwards.
- FSM: IDLE, SHIFT, COMMIT.
  - IDLE, pend_combo=1: load combo_reg, clear pend_combo, src=COMBO → SHIFT.
  - IDLE, pend_score=1, hold timer=0 (no combo on hold): load score_reg, clear pend_score, src=SCORE → SHIFT.
  - Combo has strict priority. Score requests during a combo hold stay pending.
  - Load: operand = min(value, SAT_MAX); BCD accumulator = 0; iteration counter = 0.
  - SHIFT: one double-dabble iteration per cycle.
    - Add 3 to every BCD nibble ≥5.
    - Shift {bcd, operand} left by 1.
    - After 20 iterations → COMMIT.
  - COMMIT:
    - Register the digits, compute blank, set showing_combo = (src==COMBO) → IDLE.
    - If src==COMBO, load hold timer with HOLD_CYCLES.
- Latency: a valid sampled at edge N reaches the outputs at edge N+22.
  - N+1: load.
  - N+2..N+21: 20 shifts.
  - N+22: commit.
  - This holds if the engine is idle at N. Otherwise the request starts in the first IDLE cycle after the current commit.
- Hold timer:
  - Decrements once per cycle while nonzero.
  - On the transition to 0, sets pend_score, which re-displays the latest score_reg.
  - showing_combo drops at that score's commit, not at timer expiry.
  - A new combo commit during hold reloads the timer to HOLD_CYCLES.
- Blank: bit 0 is always 0. Bit k (k=1..5) = 1 iff digits k..5 are all zero. Value 0 displays a single "0".
- Simultaneous score_valid and combo_valid: both captured; combo converts first; score shows after the hold expires.
- Outputs change only at COMMIT (or reset). They are never partially updated.

Test Plan:
- Reset, then score_value=146 with score_valid at edge N:
  - busy=1 from N+1.
  - Digits {5..0} = 0,0,0,1,4,6 and blank = 6'b111000 at N+22.
  - busy=0 after N+22.
- score_value=20'hFFFFF (1048575), pulse → digits 9,9,9,9,9,9, blank = 0 (saturation). Then score_value=0 → digits all 0, blank = 6'b111110.
- HOLD_CYCLES=10, score=500 displayed, combo_value=25 pulsed:
  - Digits show 25 with showing_combo=1 for 10 cycles after commit.
  - Then 500 re-converts automatically and showing_combo=0 at its commit.
- score_valid(777) and combo_valid(3) in the same cycle:
  - 3 commits first, with showing_combo=1.
  - 777 commits only after the hold expires.
  - No display of 777 before then.
- Score pulses 100 at N, 200 at N+5, 300 at N+10:
  - 100 commits at N+22.
  - Only 300 converts next (200 overwritten) and commits at N+44.
- reset_n low at N+10 of a 999999 conversion:
  - Outputs return to reset values immediately.
  - No commit follows.
  - After release, the controller is idle until a new valid pulse arrives.
